// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [1:0] OP_MULT  = 2'b00,
   parameter logic [1:0] OP_MULTU = 2'b01,
   parameter logic [1:0] OP_DIV   = 2'b10,
   parameter logic [1:0] OP_DIVU  = 2'b11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             flush,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state, state_nxt;
   logic               accept, mt_wr, iterate, fix_wr;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic               div_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               busy_r, done_r;

   logic               in_signed, in_div, in_a_neg, in_b_neg;
   logic [WIDTH-1:0]   in_a_mag, in_b_mag;

   assign in_signed = (op == OP_MULT) || (op == OP_DIV);
   assign in_div    = !((op == OP_MULT) || (op == OP_MULTU));
   assign in_a_neg  = in_signed & operand_a[WIDTH-1];
   assign in_b_neg  = in_signed & operand_b[WIDTH-1];
   assign in_a_mag  = in_a_neg ? -operand_a : operand_a;
   assign in_b_mag  = in_b_neg ? -operand_b : operand_b;

   // Multiply: multiplier sits in the low half and is shifted out as the product fills in.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
   assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   // Divide: remainder in the high half, dividend bits shift out of the low half as quotient bits enter.
   logic [WIDTH+1:0]   div_trial;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_nxt;
   assign div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, b_mag};
   assign div_ok    = ~div_trial[WIDTH+1];
   assign div_nxt   = {(div_ok ? div_trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                       acc[WIDTH-2:0], div_ok};

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   raw_a, res_hi, res_lo;
   assign prod  = (a_neg ^ b_neg) ? -acc : acc;
   assign raw_a = a_neg ? -a_mag : a_mag;

   always_comb begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (div_op) begin
         if (b_mag == '0) begin
            res_hi = raw_a;
            res_lo = '1;
         end else begin
            res_hi = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_CALC;
         S_CALC:  if (flush) state_nxt = S_IDLE;
                  else if (cnt == '0) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accept  = 1'b0;
      mt_wr   = 1'b0;
      iterate = 1'b0;
      fix_wr  = 1'b0;
      case (state)
         S_IDLE: begin
            accept = start & ~flush;
            mt_wr  = ~start & ~flush;
         end
         S_CALC:  iterate = ~flush;
         S_FIX:   fix_wr  = ~flush;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r   <= '0;
         lo_r   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         div_op <= 1'b0;
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         a_mag  <= '0;
         b_mag  <= '0;
      end else begin
         busy_r <= (state_nxt != S_IDLE);
         done_r <= fix_wr;
         if (accept) begin
            div_op <= in_div;
            a_neg  <= in_a_neg;
            b_neg  <= in_b_neg;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            cnt    <= CNT_W'(WIDTH - 1);
            acc    <= {{WIDTH{1'b0}}, (in_div ? in_a_mag : in_b_mag)};
         end
         if (iterate) begin
            acc <= div_op ? div_nxt : mul_nxt;
            cnt <= cnt - 1'b1;
         end
         if (mt_wr) begin
            if (mthi) hi_r <= operand_a;
            if (mtlo) lo_r <= operand_a;
         end
         if (fix_wr) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
         end
      end
   end

   assign hi   = hi_r;
   assign lo   = lo_r;
   assign busy = busy_r;
   assign done = done_r;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : vector table, corner sequences and random ops vs. arithmetic model
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst, start, flush, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] operand_a, operand_b, hi, lo;
   logic        busy, done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
      .mthi(mthi), .mtlo(mtlo), .operand_a(operand_a), .operand_b(operand_b),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] mh, output logic [31:0] ml);
      longint sa, sb, p, q, r;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         OP_MULT: begin
            p = sa * sb;
            mh = p[63:32]; ml = p[31:0];
         end
         OP_MULTU: begin
            up = ua * ub;
            mh = up[63:32]; ml = up[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) begin mh = a; ml = 32'hFFFF_FFFF; end
            else begin
               q = sa / sb; r = sa % sb;
               mh = r[31:0]; ml = q[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin mh = a; ml = 32'hFFFF_FFFF; end
            else begin mh = a % b; ml = a / b; end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // flush_at=k asserts flush so it is sampled on the k-th edge after accept (0 = no flush)
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at, input bit disturb,
                         input logic [31:0] eh, input logic [31:0] el);
      int n, busy_cnt;
      bit seen;
      @(negedge clk);
      start = 1; op = o; operand_a = a; operand_b = b; flush = 0; mthi = 0; mtlo = 0;
      @(negedge clk);
      start = 0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      n = 0; busy_cnt = 0; seen = 0;
      while (!seen && n < 40) begin
         if (busy) busy_cnt++;
         if (done) seen = 1;
         else begin
            start = disturb && (n == 5);
            mthi  = disturb && (n == 5);
            mtlo  = disturb && (n == 5);
            flush = (flush_at > 0) && (n == flush_at - 1);
            @(negedge clk);
            n++;
         end
      end
      start = 0; mthi = 0; mtlo = 0; flush = 0;
      if (flush_at == 0) begin
         check({name, " latency"}, 64'(n), 64'd33);
         check({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
         check({name, " hi"}, hi, eh);
         check({name, " lo"}, lo, el);
         @(negedge clk);
         check({name, " done_fall"}, done, 0);
      end else begin
         check({name, " done_seen"}, seen, 0);
         check({name, " busy_cycles"}, 64'(busy_cnt), 64'(flush_at));
         check({name, " hi"}, hi, eh);
         check({name, " lo"}, lo, el);
      end
   endtask

   initial begin
      logic [31:0] eh, el, ra, rb;
      logic [1:0]  ro;

      vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
      vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{OP_DIVU,  32'd10,        32'd3,         32'd1,         32'd3};
      vecs[6]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[7]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[9]  = '{OP_MULTU, 32'h8000_0000, 32'd2,         32'd1,         32'd0};
      vecs[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
      vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

      rst = 1; start = 0; flush = 0; mthi = 0; mtlo = 0; op = 0; operand_a = 0; operand_b = 0;
      repeat (2) @(negedge clk);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      rst = 0;

      @(negedge clk); mthi = 1; operand_a = 32'h1234;
      @(negedge clk); mthi = 0; mtlo = 1; operand_a = 32'h5678;
      @(negedge clk); mtlo = 0;
      check("mthi", hi, 32'h1234);
      check("mtlo", lo, 32'h5678);

      run_op("divu_flush_calc", OP_DIVU, 32'd10, 32'd3, 10, 0, 32'h1234, 32'h5678);
      run_op("mult_flush_fix", OP_MULT, 32'hFFFF_FFFD, 32'd7, 33, 0, 32'h1234, 32'h5678);

      // start wins over mt* in IDLE; the op is then flushed so HI/LO must be untouched
      @(negedge clk); start = 1; mthi = 1; mtlo = 1; op = OP_DIVU; operand_a = 32'hAAAA; operand_b = 32'd3;
      @(negedge clk); start = 0; mthi = 0; mtlo = 0; flush = 1;
      check("start_dom busy", busy, 1);
      @(negedge clk); flush = 0;
      check("start_dom hi", hi, 32'h1234);
      check("start_dom lo", lo, 32'h5678);
      check("start_dom flushed busy", busy, 0);

      @(negedge clk); flush = 1; start = 1; mthi = 1; mtlo = 1; operand_a = 32'hDEAD;
      @(negedge clk); flush = 0; start = 0; mthi = 0; mtlo = 0;
      check("flush_dom busy", busy, 0);
      check("flush_dom hi", hi, 32'h1234);
      check("flush_dom lo", lo, 32'h5678);

      @(negedge clk); mthi = 1; mtlo = 1; operand_a = 32'hCAFE;
      @(negedge clk); mthi = 0; mtlo = 0;
      check("mt_both hi", hi, 32'hCAFE);
      check("mt_both lo", lo, 32'hCAFE);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, vecs[i].hi, vecs[i].lo);

      run_op("busy_ignore", OP_MULTU, 32'd3, 32'd5, 0, 1, 32'd0, 32'd15);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         model(ro, ra, rb, eh, el);
         run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, 0, ($urandom_range(0, 3) == 0), eh, el);
      end

      // reset in the middle of an operation after HI/LO hold a result
      @(negedge clk); start = 1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd5;
      @(negedge clk); start = 0;
      repeat (4) @(negedge clk);
      rst = 1;
      @(negedge clk); rst = 0;
      check("midrst hi", hi, 0);
      check("midrst lo", lo, 0);
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      run_op("post_rst", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
